// File: rtl/iir_sched_pkg.sv
// Shared defaults and the recursive-section update step for iir_ch_sched.
package iir_sched_pkg;

    localparam int unsigned W_DEF   = 14;
    localparam int unsigned N_DEF   = 4;
    localparam int unsigned CHW_DEF = $clog2(N_DEF);

    // x + (y>>>1) + (y>>>2), wrapped to w+1 bits and sign-extended back to 32.
    // Callers pass operands already sign-extended to 32 bits; the arithmetic
    // shifts of the extended value equal those of the narrow value.
    function automatic logic signed [31:0] iir_step(
        input logic signed [31:0] x,
        input logic signed [31:0] y,
        input int unsigned        w
    );
        logic signed [31:0] s;
        s = x + (y >>> 1) + (y >>> 2);
        return (s <<< (31 - w)) >>> (31 - w);
    endfunction

endpackage

// File: rtl/iir_ch_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping.
module rr_arbiter
    import iir_sched_pkg::*;
#(
    parameter int unsigned N   = N_DEF,
    parameter int unsigned CHW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [CHW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [CHW-1:0] gnt_idx,
    output logic           any
);

    logic [CHW-1:0] idx;

    // Scan channels starting at ptr; the first set request wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = CHW'((32'(ptr) + i) % N);
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/iir_ch_sched.sv
// Time-multiplexed first-order IIR, y <= x + (y>>>1) + (y>>>2), over N channels.
// Two-stage pipeline: A captures sample and state, B computes and writes back.
module iir_ch_sched
    import iir_sched_pkg::*;
#(
    parameter int unsigned W   = W_DEF,
    parameter int unsigned N   = N_DEF,
    parameter int unsigned CHW = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N*(W+1)-1:0] x_in,
    input  logic [N-1:0]       x_valid,
    output logic [N-1:0]       x_ready,
    input  logic               clr,
    input  logic [CHW-1:0]     clr_ch,
    output logic [W:0]         y_out,
    output logic [CHW-1:0]     y_ch,
    output logic               y_valid
);

    logic signed [W:0] y_st [N];
    logic signed [W:0] x_arr [N];

    logic [CHW-1:0]    ptr;
    logic [N-1:0]      gnt;
    logic [CHW-1:0]    g;
    logic              acc;

    logic signed [W:0] xa;
    logic signed [W:0] ya;
    logic [CHW-1:0]    cha;
    logic              va;

    logic signed [W:0] yn;
    logic signed [W:0] ya_nxt;

    rr_arbiter #(.N(N), .CHW(CHW)) u_arb (
        .req     (x_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (g),
        .any     (acc)
    );

    // Grant is hidden while reset is held so no accept is signalled.
    assign x_ready = gnt & {N{reset_n}};

    // Unpack the flat sample bus into per-channel lanes.
    always_comb begin
        for (int unsigned c = 0; c < N; c++) begin
            x_arr[c] = x_in[c*(W+1) +: W+1];
        end
    end

    // Stage B update value, wrapped to W+1 bits.
    assign yn = (W+1)'(iir_step(32'(xa), 32'(ya), W));

    // Stage A state read with bypass from stage B; a same-cycle clear beats it.
    always_comb begin
        ya_nxt = y_st[g];
        if (clr && (clr_ch == g)) begin
            ya_nxt = '0;
        end else if (va && (cha == g)) begin
            ya_nxt = yn;
        end
    end

    // Round-robin pointer advances past the granted channel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (acc) begin
            ptr <= CHW'((32'(g) + 1) % N);
        end
    end

    // Stage A register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            va  <= 1'b0;
            xa  <= '0;
            ya  <= '0;
            cha <= '0;
        end else begin
            va <= acc;
            if (acc) begin
                xa  <= x_arr[g];
                ya  <= ya_nxt;
                cha <= g;
            end
        end
    end

    // Stage B result register; y_out/y_ch hold when no result is produced.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_valid <= 1'b0;
            y_out   <= '0;
            y_ch    <= '0;
        end else begin
            y_valid <= va;
            if (va) begin
                y_out <= yn;
                y_ch  <= cha;
            end
        end
    end

    // Per-channel state: clear has priority over the stage B write-back.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned c = 0; c < N; c++) begin
                y_st[c] <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < N; c++) begin
                if (clr && (clr_ch == CHW'(c))) begin
                    y_st[c] <= '0;
                end else if (va && (cha == CHW'(c))) begin
                    y_st[c] <= yn;
                end
            end
        end
    end

endmodule

// File: tb/tb_iir_ch_sched.sv
// Directed bench for iir_ch_sched with hand-computed expected values (W=14, N=4).
module tb_iir_ch_sched;

    localparam int unsigned W   = 14;
    localparam int unsigned N   = 4;
    localparam int unsigned CHW = 2;

    logic               clk;
    logic               reset_n;
    logic [N*(W+1)-1:0] x_in;
    logic [N-1:0]       x_valid;
    logic [N-1:0]       x_ready;
    logic               clr;
    logic [CHW-1:0]     clr_ch;
    logic [W:0]         y_out;
    logic [CHW-1:0]     y_ch;
    logic               y_valid;

    int n_chk;
    int n_err;

    iir_ch_sched #(.W(W), .N(N), .CHW(CHW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .x_in    (x_in),
        .x_valid (x_valid),
        .x_ready (x_ready),
        .clr     (clr),
        .clr_ch  (clr_ch),
        .y_out   (y_out),
        .y_ch    (y_ch),
        .y_valid (y_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_x(input int c, input int v);
        logic [31:0] t;
        t = v;
        x_in[c*(W+1) +: W+1] = t[W:0];
    endtask

    task automatic chk_out(input string tag, input int ch, input int v);
        chk({tag, "_valid"}, 32'(y_valid), 1);
        chk({tag, "_ch"}, 32'(y_ch), ch);
        chk({tag, "_y"}, $signed(y_out), v);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        x_valid = '0;
        clr     = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk   = 0;
        n_err   = 0;
        x_in    = '0;
        x_valid = '0;
        clr     = 1'b0;
        clr_ch  = '0;
        reset_n = 1'b1;
        #2;

        // Reset state, with a request pending to show x_ready is masked.
        reset_n = 1'b0;
        x_valid = 4'b1111;
        #1;
        chk("rst_ready", 32'(x_ready), 0);
        tick();
        chk("rst_valid", 32'(y_valid), 0);
        chk("rst_y", $signed(y_out), 0);
        chk("rst_ch", 32'(y_ch), 0);
        x_valid = '0;
        tick();
        reset_n = 1'b1;

        // Single channel positive: 1000, 1750, 2312, 2734, 3050.
        set_x(0, 1000);
        x_valid = 4'b0001;
        #1;
        chk("p_ready", 32'(x_ready), 4'b0001);
        tick();
        chk("p_lat", 32'(y_valid), 0);
        tick(); chk_out("p1", 0, 1000);
        tick(); chk_out("p2", 0, 1750);
        tick(); chk_out("p3", 0, 2312);
        tick(); chk_out("p4", 0, 2734);
        x_valid = '0;
        tick(); chk_out("p5", 0, 3050);
        tick();
        chk("p_idle", 32'(y_valid), 0);
        chk("p_hold", $signed(y_out), 3050);

        // Single channel negative (pointer now at 1): -1000, -1750, -2313.
        set_x(1, -1000);
        x_valid = 4'b0010;
        #1;
        chk("n_ready", 32'(x_ready), 4'b0010);
        tick();
        tick(); chk_out("n1", 1, -1000);
        tick(); chk_out("n2", 1, -1750);
        x_valid = '0;
        tick(); chk_out("n3", 1, -2313);
        tick();
        chk("n_idle", 32'(y_valid), 0);

        // Round-robin on fresh state: grants 0,1,2,3,0,...; second = 1.75*first.
        do_reset();
        for (int c = 0; c < 4; c++) set_x(c, 100 * (c + 1));
        x_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("rr_ready", 32'(x_ready), 32'(1) << (i % 4));
            tick();
            if (i >= 1) begin
                chk_out("rr", (i - 1) % 4,
                        (i - 1 < 4) ? 100 * ((i - 1) % 4 + 1) : 175 * ((i - 1) % 4 + 1));
            end
        end
        x_valid = '0;
        tick(); chk_out("rr_last", 3, 700);
        tick();
        chk("rr_idle", 32'(y_valid), 0);

        // Wrap: 16383; 16383+8191+4095=28669 -> -4099; 16383-2050-1025=13308.
        do_reset();
        set_x(3, 16383);
        x_valid = 4'b1000;
        tick();
        tick(); chk_out("w1", 3, 16383);
        tick(); chk_out("w2", 3, -4099);
        x_valid = '0;
        tick(); chk_out("w3", 3, 13308);
        tick();

        // Clear colliding with the ch2 write-back of 2312.
        do_reset();
        set_x(2, 1000);
        x_valid = 4'b0100;
        tick();
        tick(); chk_out("c1", 2, 1000);
        tick(); chk_out("c2", 2, 1750);
        x_valid = '0;
        clr     = 1'b1;
        clr_ch  = 2'd2;
        tick(); chk_out("c3", 2, 2312);
        clr = 1'b0;
        tick();
        x_valid = 4'b0100;
        #1;
        chk("c_ready", 32'(x_ready), 4'b0100);
        tick();
        x_valid = '0;
        tick(); chk_out("c_after", 2, 1000);

        // Reset mid-stream with ch0 in stage A and ch1 about to be accepted.
        tick();
        set_x(0, 500);
        set_x(1, 600);
        x_valid = 4'b0011;
        tick();
        reset_n = 1'b0;
        #1;
        chk("mr_ready", 32'(x_ready), 0);
        tick();
        chk("mr_valid0", 32'(y_valid), 0);
        x_valid = '0;
        reset_n = 1'b1;
        tick();
        chk("mr_valid1", 32'(y_valid), 0);
        tick();
        chk("mr_valid2", 32'(y_valid), 0);

        // After reset: pointer at ch0 and every state zero, so y equals x.
        for (int c = 0; c < 4; c++) set_x(c, 500 + 100 * c);
        x_valid = 4'b1111;
        #1;
        chk("mr_ptr", 32'(x_ready), 4'b0001);
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) x_valid = '0;
            tick();
            chk_out("mr", i, 500 + 100 * i);
        end
        tick();
        chk("mr_idle", 32'(y_valid), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
